pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter RA_W, 5, register address width.
REQ-002 Parameter DIV_LAT, 33, divider latency in cycles; legal range is 2..255.
REQ-003 Parameter EXC_VEC, 32'hBFC00380, exception entry address.
REQ-004 Parameter ERET_CODE, 32'h0000000E, excepttype value meaning ERET.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 rs_d, rt_d  in  RA_W  decode-stage source registers.
REQ-008 rs_e, rt_e  in  RA_W  execute-stage source registers; memtoreg_e  in  1  load in E.
REQ-009 writereg_m, writereg_w  in  RA_W; regwrite_m, regwrite_w  in  1  M/W destination and write enable.
REQ-010 div_start_e  in  1  divide instruction present in E.
REQ-011 imem_busy, dmem_busy  in  1  instruction/data SRAM request outstanding.
REQ-012 excepttype_w, cp0_epc_w  in  32  W-stage exception code and EPC.
REQ-013 forward_a_e, forward_b_e  out  2  E operand select: 00 regfile, 01 W, 10 M.
REQ-014 stall_f, stall_d, stall_e, stall_m, stall_w  out  1  per-stage hold.
REQ-015 flush_f, flush_d, flush_e, flush_m, flush_w  out  1  per-stage bubble.
REQ-016 div_busy  out  1  divider stall active; redirect_valid  out  1  one-cycle PC redirect strobe; redirect_pc  out  32  redirect target.

Function
REQ-017 Forwarding SHALL be combinational: M has priority over W; a register number of 0 is never forwarded.
REQ-018 Load-use hazard (memtoreg_e, rt_e!=0, rt_e equal to rs_d or rt_d) SHALL assert stall_f, stall_d and flush_e.
REQ-019 Divider FSM SHALL have states DIV_IDLE, DIV_RUN and DIV_DONE.
REQ-020 DIV_IDLE with div_start_e and no exception SHALL go to DIV_RUN and load the counter with DIV_LAT-1; the stall SHALL already be asserted in this cycle.
REQ-021 DIV_RUN SHALL decrement the counter each cycle and go to DIV_DONE at 0; DIV_DONE SHALL release the stall and return to DIV_IDLE next cycle, whatever div_start_e is; total stall SHALL be exactly DIV_LAT cycles.
REQ-022 While the divider stalls, div_busy SHALL be 1 and stall_f through stall_w SHALL be 1.
REQ-023 dmem_busy SHALL assert stall_f, stall_d, stall_e and stall_m, plus flush_w.
REQ-024 imem_busy alone SHALL assert stall_f and stall_d, plus flush_e, unless E is stalled.
REQ-025 Exception FSM SHALL have states EX_IDLE and EX_WAIT.
REQ-026 In EX_IDLE, excepttype_w!=0 SHALL assert all five flushes that cycle and latch redirect_pc: cp0_epc_w if the code equals ERET_CODE, else EXC_VEC.
REQ-027 If neither SRAM is busy, redirect_valid SHALL pulse high for 1 cycle on the next cycle; otherwise the FSM SHALL enter EX_WAIT.
REQ-028 EX_WAIT SHALL hold stall_f and flush_d..flush_w high; redirect_valid SHALL pulse on the cycle after both busy inputs are low, and the FSM SHALL then return to EX_IDLE.
REQ-029 excepttype_w SHALL be ignored in EX_WAIT; an exception SHALL force the divider FSM to DIV_IDLE.
REQ-030 Priority: exception > dmem/divider > load-use > imem; a stall and a flush of the same stage SHALL never both be high, and flush wins.

Reset
REQ-031 On rst: both FSMs SHALL be idle, the counter 0, redirect_valid 0 and redirect_pc 0.
REQ-032 Reset SHALL override an in-progress divide or exception wait; all stall and flush outputs SHALL be 0 in the cycle after reset, given idle inputs.

Structure
REQ-033 A package hazard_pkg SHALL hold the forward-select encodings (FWD_NONE, FWD_W, FWD_M), the FSM state types and the EXC_VEC/ERET_CODE defaults.
REQ-034 The divider FSM and counter SHALL be one sub-module, div_stall_counter; everything else stays flat.

Verification
REQ-035 rs_e=3, writereg_m=3, regwrite_m=1, writereg_w=3, regwrite_w=1 -> forward_a_e=10; rs_e=0 -> 00.
REQ-036 memtoreg_e=1, rt_e=5, rs_d=5 -> stall_f=stall_d=flush_e=1, stall_e=0.
REQ-037 DIV_LAT=4, div_start_e held high -> div_busy high exactly 4 cycles, 1 cycle low, no restart.
REQ-038 excepttype_w=1 with dmem_busy high 3 cycles -> flushes asserted, redirect_valid pulse 1 cycle after busy falls, redirect_pc=BFC00380.
REQ-039 excepttype_w=0000000E, cp0_epc_w=BFC00100, no busy -> redirect_valid next cycle with BFC00100; rst asserted mid-divide -> div_busy 0 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Holds operand-forward selects, the divider/exception FSM state types and the
// default exception vector / ERET code used as parameter defaults by the top.
package hazard_pkg;

  // Execute-stage operand source select
  localparam logic [1:0] FWD_NONE = 2'b00;  // register file
  localparam logic [1:0] FWD_W    = 2'b01;  // writeback-stage result
  localparam logic [1:0] FWD_M    = 2'b10;  // memory-stage result

  // Divider stall FSM
  typedef logic [1:0] divState_t;
  localparam divState_t DIV_IDLE = 2'd0;
  localparam divState_t DIV_RUN  = 2'd1;
  localparam divState_t DIV_DONE = 2'd2;

  // Exception redirect FSM
  typedef logic exState_t;
  localparam exState_t EX_IDLE = 1'b0;
  localparam exState_t EX_WAIT = 1'b1;

  localparam logic [31:0] EXC_VEC_DEFAULT   = 32'hBFC00380;
  localparam logic [31:0] ERET_CODE_DEFAULT = 32'h0000000E;

endpackage

// File: rtl/div_stall_counter.sv
// Divider stall sequencer: holds the pipeline for exactly DIV_LAT cycles per divide.
// Latency: divBusy is combinational from divStart in the start cycle, then registered.
// Backpressure: abort (exception) drops the stall immediately and returns to idle.
// Ports: clk, rst (sync, active-high), divStart (divide in E), abort (exception
//        in progress), divBusy (stall request to the hazard unit).
module div_stall_counter
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = 33
) (
  input  logic clk,
  input  logic rst,
  input  logic divStart,
  input  logic abort,
  output logic divBusy
);

  localparam logic [7:0] LOAD_VAL = 8'(DIV_LAT - 1);

  divState_t  divState;
  logic [7:0] divCnt;

  // The start cycle already stalls, so RUN only has to cover DIV_LAT-1 more.
  always_comb begin
    divBusy = 1'b0;
    if (!abort) begin
      case (divState)
        DIV_IDLE: divBusy = divStart;
        DIV_RUN:  divBusy = 1'b1;
        default:  divBusy = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divState <= DIV_IDLE;
      divCnt   <= '0;
    end else if (abort) begin
      divState <= DIV_IDLE;
      divCnt   <= '0;
    end else begin
      case (divState)
        DIV_IDLE: begin
          if (divStart) begin
            divState <= DIV_RUN;
            divCnt   <= LOAD_VAL;
          end
        end
        DIV_RUN: begin
          divCnt <= divCnt - 8'd1;
          // Counter reaches zero on this edge: the stall ends here.
          if (divCnt <= 8'd1) begin
            divState <= DIV_DONE;
          end
        end
        // One released cycle lets the divide leave E before another can start.
        DIV_DONE: divState <= DIV_IDLE;
        default:  divState <= DIV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard unit: forwarding, load-use, SRAM and divider stalls, exception redirect.
// Latency: forwarding/stall/flush are combinational; redirect_valid/redirect_pc are registered.
// Backpressure: busy SRAMs hold stages; an exception waits for both SRAMs idle before redirecting.
// Ports: clk/rst (sync, active-high); D/E/M/W register ids and write enables; div_start_e;
//        imem_busy/dmem_busy; excepttype_w/cp0_epc_w in. forward_a_e/forward_b_e,
//        stall_*/flush_* per stage, div_busy, redirect_valid/redirect_pc out.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int          RA_W      = 5,
  parameter int          DIV_LAT   = 33,
  parameter logic [31:0] EXC_VEC   = EXC_VEC_DEFAULT,
  parameter logic [31:0] ERET_CODE = ERET_CODE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RA_W-1:0] rs_d,
  input  logic [RA_W-1:0] rt_d,
  input  logic [RA_W-1:0] rs_e,
  input  logic [RA_W-1:0] rt_e,
  input  logic            memtoreg_e,
  input  logic [RA_W-1:0] writereg_m,
  input  logic [RA_W-1:0] writereg_w,
  input  logic            regwrite_m,
  input  logic            regwrite_w,
  input  logic            div_start_e,
  input  logic            imem_busy,
  input  logic            dmem_busy,
  input  logic [31:0]     excepttype_w,
  input  logic [31:0]     cp0_epc_w,
  output logic [1:0]      forward_a_e,
  output logic [1:0]      forward_b_e,
  output logic            stall_f,
  output logic            stall_d,
  output logic            stall_e,
  output logic            stall_m,
  output logic            stall_w,
  output logic            flush_f,
  output logic            flush_d,
  output logic            flush_e,
  output logic            flush_m,
  output logic            flush_w,
  output logic            div_busy,
  output logic            redirect_valid,
  output logic [31:0]     redirect_pc
);

  // M is younger than W, so its value wins; r0 is hardwired zero.
  function automatic logic [1:0] fwdSelect(
    input logic [RA_W-1:0] src,
    input logic [RA_W-1:0] mReg,
    input logic            mWe,
    input logic [RA_W-1:0] wReg,
    input logic            wWe
  );
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src != '0) begin
      if (mWe && (mReg == src))      sel = FWD_M;
      else if (wWe && (wReg == src)) sel = FWD_W;
    end
    return sel;
  endfunction

  assign forward_a_e = fwdSelect(rs_e, writereg_m, regwrite_m, writereg_w, regwrite_w);
  assign forward_b_e = fwdSelect(rt_e, writereg_m, regwrite_m, writereg_w, regwrite_w);

  exState_t exState;
  logic     excRaise;
  logic     sramBusy;
  logic     divAbort;
  logic     divBusy;
  logic     loadUse;

  assign sramBusy = imem_busy | dmem_busy;
  // excepttype_w is only looked at when no redirect is already pending.
  assign excRaise = (exState == EX_IDLE) && (excepttype_w != '0);
  // The E-stage divide is being flushed, so the divider must not run or start.
  assign divAbort = excRaise || (exState == EX_WAIT);

  assign loadUse = memtoreg_e && (rt_e != '0) && ((rt_e == rs_d) || (rt_e == rt_d));

  div_stall_counter #(
    .DIV_LAT (DIV_LAT)
  ) u_divStall (
    .clk      (clk),
    .rst      (rst),
    .divStart (div_start_e),
    .abort    (divAbort),
    .divBusy  (divBusy)
  );

  assign div_busy = divBusy;

  always_ff @(posedge clk) begin
    if (rst) begin
      exState        <= EX_IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= 1'b0;
      if (exState == EX_IDLE) begin
        if (excRaise) begin
          redirect_pc <= (excepttype_w == ERET_CODE) ? cp0_epc_w : EXC_VEC;
          if (!sramBusy) redirect_valid <= 1'b1;
          else           exState        <= EX_WAIT;
        end
      end else begin
        // Redirect only once no SRAM response can land in the flushed pipe.
        if (!sramBusy) begin
          redirect_valid <= 1'b1;
          exState        <= EX_IDLE;
        end
      end
    end
  end

  // Bit order {F, D, E, M, W}.
  logic [4:0] stallVec;
  logic [4:0] flushVec;

  always_comb begin
    stallVec = '0;
    flushVec = '0;
    if (excRaise) begin
      flushVec = 5'b11111;
    end else if (exState == EX_WAIT) begin
      stallVec = 5'b10000;
      flushVec = 5'b01111;
    end else if (divBusy || dmem_busy) begin
      if (divBusy) stallVec = 5'b11111;
      if (dmem_busy) begin
        stallVec = stallVec | 5'b11110;
        flushVec = 5'b00001;
      end
    end else if (loadUse || imem_busy) begin
      // E is never stalled in this branch, so the imem bubble always applies.
      stallVec = 5'b11000;
      flushVec = 5'b00100;
    end
  end

  // A flushed stage is never also held.
  assign {stall_f, stall_d, stall_e, stall_m, stall_w} = stallVec & ~flushVec;
  assign {flush_f, flush_d, flush_e, flush_m, flush_w} = flushVec;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus randomized
// stimulus compared cycle by cycle against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int          RA_W    = 5;
  localparam int          DIV_LAT = 4;
  localparam logic [31:0] EXC_VEC = 32'hBFC00380;
  localparam logic [31:0] ERET    = 32'h0000000E;

  logic            clk;
  logic            rst;
  logic [RA_W-1:0] rs_d, rt_d, rs_e, rt_e, writereg_m, writereg_w;
  logic            memtoreg_e, regwrite_m, regwrite_w, div_start_e;
  logic            imem_busy, dmem_busy;
  logic [31:0]     excepttype_w, cp0_epc_w;
  logic [1:0]      forward_a_e, forward_b_e;
  logic            stall_f, stall_d, stall_e, stall_m, stall_w;
  logic            flush_f, flush_d, flush_e, flush_m, flush_w;
  logic            div_busy, redirect_valid;
  logic [31:0]     redirect_pc;

  pipe_hazard_ctrl #(
    .RA_W(RA_W), .DIV_LAT(DIV_LAT), .EXC_VEC(EXC_VEC), .ERET_CODE(ERET)
  ) dut (
    .clk(clk), .rst(rst),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e), .memtoreg_e(memtoreg_e),
    .writereg_m(writereg_m), .writereg_w(writereg_w),
    .regwrite_m(regwrite_m), .regwrite_w(regwrite_w),
    .div_start_e(div_start_e), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .excepttype_w(excepttype_w), .cp0_epc_w(cp0_epc_w),
    .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m), .stall_w(stall_w),
    .flush_f(flush_f), .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m), .flush_w(flush_w),
    .div_busy(div_busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errCnt = 0;
  int chkCnt = 0;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chkCnt++;
    if (obs !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state, expressed as "what is pending" rather than FSM states.
  int          divLeft  = 0;  // further stalled cycles of the current divide
  bit          divCool  = 0;  // the one released cycle after a divide
  bit          exPend   = 0;  // redirect waiting for the SRAMs to go idle
  bit          redirV   = 0;
  logic [31:0] redirPc  = '0;

  function automatic logic [1:0] fwdModel(input logic [RA_W-1:0] src);
    if (src == 0) return 2'b00;
    if (regwrite_m && writereg_m == src) return 2'b10;
    if (regwrite_w && writereg_w == src) return 2'b01;
    return 2'b00;
  endfunction

  // Check all outputs against the model at the falling edge, then advance the
  // model across the next rising edge. Called just after a rising edge.
  task automatic stepCycle();
    bit         excNow, divStall, busyAny, lu;
    logic [4:0] expSt, expFl;
    @(negedge clk);
    busyAny  = imem_busy || dmem_busy;
    excNow   = !exPend && (excepttype_w != 0);
    divStall = 0;
    if (!(excNow || exPend)) begin
      if (divLeft > 0)  divStall = 1;
      else if (!divCool) divStall = div_start_e;
    end
    lu = memtoreg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
    expSt = '0;
    expFl = '0;
    if (excNow) expFl = 5'b11111;
    else if (exPend) begin expSt = 5'b10000; expFl = 5'b01111; end
    else if (divStall || dmem_busy) begin
      if (divStall) expSt = 5'b11111;
      if (dmem_busy) begin expSt = expSt | 5'b11110; expFl = 5'b00001; end
    end else if (lu || imem_busy) begin
      expSt = 5'b11000; expFl = 5'b00100;
    end
    expSt = expSt & ~expFl;
    if (!rst) begin
      checkEq("fwdA", 32'(forward_a_e), 32'(fwdModel(rs_e)));
      checkEq("fwdB", 32'(forward_b_e), 32'(fwdModel(rt_e)));
      checkEq("stalls", 32'({stall_f, stall_d, stall_e, stall_m, stall_w}), 32'(expSt));
      checkEq("flushes", 32'({flush_f, flush_d, flush_e, flush_m, flush_w}), 32'(expFl));
      checkEq("divBusy", 32'(div_busy), 32'(divStall));
      checkEq("redirValid", 32'(redirect_valid), 32'(redirV));
      checkEq("redirPc", redirect_pc, redirPc);
    end
    if (rst) begin
      divLeft = 0; divCool = 0; exPend = 0; redirV = 0; redirPc = '0;
    end else begin
      redirV = 0;
      if (excNow || exPend) begin
        divLeft = 0; divCool = 0;
      end else if (divLeft > 0) begin
        divLeft--;
        if (divLeft == 0) divCool = 1;
      end else if (divCool) begin
        divCool = 0;
      end else if (div_start_e) begin
        divLeft = DIV_LAT - 1;
      end
      if (excNow) begin
        redirPc = (excepttype_w == ERET) ? cp0_epc_w : EXC_VEC;
        if (!busyAny) redirV = 1;
        else          exPend = 1;
      end else if (exPend && !busyAny) begin
        redirV = 1;
        exPend = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0; memtoreg_e = 0;
    writereg_m = '0; writereg_w = '0; regwrite_m = 0; regwrite_w = 0;
    div_start_e = 0; imem_busy = 0; dmem_busy = 0;
    excepttype_w = '0; cp0_epc_w = '0;
  endtask

  int          busyCnt;
  logic [4:0]  busyHist;
  int          r;

  initial begin
    idleInputs();
    rst = 1;
    stepCycle();
    rst = 0;
    #1;
    checkEq("rstRedirValid", 32'(redirect_valid), 32'd0);
    checkEq("rstRedirPc", redirect_pc, 32'd0);
    checkEq("rstStallFlush", 32'({stall_f, stall_d, stall_e, stall_m, stall_w,
                                  flush_f, flush_d, flush_e, flush_m, flush_w}), 32'd0);
    stepCycle();

    // Forwarding: M beats W; r0 never forwarded
    rs_e = 5'd3; writereg_m = 5'd3; regwrite_m = 1; writereg_w = 5'd3; regwrite_w = 1;
    #1 checkEq("fwdPrioM", 32'(forward_a_e), 32'(2'b10));
    stepCycle();
    rs_e = 5'd0;
    #1 checkEq("fwdZeroReg", 32'(forward_a_e), 32'(2'b00));
    stepCycle();
    idleInputs();

    // Load-use
    memtoreg_e = 1; rt_e = 5'd5; rs_d = 5'd5;
    #1 checkEq("loadUse", 32'({stall_f, stall_d, flush_e, stall_e}), 32'(4'b1110));
    stepCycle();
    idleInputs();
    stepCycle();

    // Divider: start held through the stall and the release cycle
    div_start_e = 1;
    busyCnt = 0;
    busyHist = '0;
    for (int i = 0; i < 5; i++) begin
      #1;
      busyCnt += int'(div_busy);
      busyHist = {busyHist[3:0], div_busy};
      stepCycle();
    end
    checkEq("divBusyCount", 32'(busyCnt), 32'd4);
    checkEq("divBusyShape", 32'(busyHist), 32'(5'b11110));
    div_start_e = 0;
    #1 checkEq("divNoRestart", 32'(div_busy), 32'd0);
    stepCycle();

    // Exception while dmem busy for three cycles
    excepttype_w = 32'd1; dmem_busy = 1;
    #1 checkEq("excFlushAll", 32'({flush_f, flush_d, flush_e, flush_m, flush_w}), 32'(5'b11111));
    stepCycle();
    excepttype_w = '0;
    stepCycle();
    #1 checkEq("excWaitHold", 32'({stall_f, flush_d, flush_e, flush_m, flush_w}), 32'(5'b11111));
    stepCycle();
    dmem_busy = 0;
    #1 checkEq("excNoEarlyRedir", 32'(redirect_valid), 32'd0);
    stepCycle();
    checkEq("excRedirValid", 32'(redirect_valid), 32'd1);
    checkEq("excRedirPc", redirect_pc, 32'hBFC00380);
    stepCycle();
    checkEq("excRedirPulse", 32'(redirect_valid), 32'd0);
    stepCycle();

    // ERET with no busy
    excepttype_w = ERET; cp0_epc_w = 32'hBFC00100;
    stepCycle();
    excepttype_w = '0;
    checkEq("eretRedirValid", 32'(redirect_valid), 32'd1);
    checkEq("eretRedirPc", redirect_pc, 32'hBFC00100);
    stepCycle();

    // Reset in the middle of a divide
    div_start_e = 1;
    stepCycle();
    div_start_e = 0;
    stepCycle();
    rst = 1;
    stepCycle();
    rst = 0;
    checkEq("rstMidDiv", 32'(div_busy), 32'd0);
    stepCycle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rs_d = 5'($urandom_range(0, 3)); rt_d = 5'($urandom_range(0, 3));
      rs_e = 5'($urandom_range(0, 3)); rt_e = 5'($urandom_range(0, 3));
      writereg_m = 5'($urandom_range(0, 3)); writereg_w = 5'($urandom_range(0, 3));
      memtoreg_e = 1'($urandom_range(0, 1));
      regwrite_m = 1'($urandom_range(0, 1)); regwrite_w = 1'($urandom_range(0, 1));
      div_start_e = ($urandom_range(0, 3) == 0);
      imem_busy = ($urandom_range(0, 3) == 0);
      dmem_busy = ($urandom_range(0, 3) == 0);
      r = int'($urandom_range(0, 15));
      excepttype_w = (r == 0) ? 32'd1 : (r == 1) ? ERET : (r == 2) ? 32'h8 : 32'd0;
      cp0_epc_w = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      stepCycle();
    end
    rst = 0;

    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end

endmodule
